// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types: response codes and the register file's write/read FSM states.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_lite_write_capture.sv
// Latches the AW and W beats independently, in either order, and raises both_ready
// in the cycle the later of the two handshakes completes; held beats clear on the B handshake.
module axi_lite_write_capture #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic                      clear,
  output logic                      both_ready,
  output logic [ADDRESS_WIDTH-1:0]  addr,
  output logic [DATA_WIDTH-1:0]     data,
  output logic [DATA_WIDTH/8-1:0]   strb
);

  logic                     aw_held_q, aw_held_d;
  logic                     w_held_q, w_held_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [DATA_WIDTH/8-1:0]  strb_q, strb_d;
  logic                     aw_hs, w_hs;

  assign awready = enable & ~aw_held_q;
  assign wready  = enable & ~w_held_q;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  // Fires only on a new handshake, so it cannot repeat while both beats sit held.
  assign both_ready = (aw_hs | aw_held_q) & (w_hs | w_held_q) & (aw_hs | w_hs);

  assign addr = aw_held_q ? addr_q : awaddr;
  assign data = w_held_q  ? data_q : wdata;
  assign strb = w_held_q  ? strb_q : wstrb;

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      addr_d    = awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      data_d   = wdata;
      strb_d   = wstrb;
    end
    if (clear) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

endmodule

// File: rtl/axi_lite_register_file.sv
// AXI-Lite register bank with flat register export and per-register write pulses.
// Optional: AXI_LITE_REGISTER_FILE_DECODE_ERROR_EN returns SLVERR for out-of-range accesses.
//
// state   | meaning
// WR_IDLE | accepting AW/W beats in any order
// WR_RESP | write applied, bvalid held until bready
// RD_IDLE | arready high, waiting for AR
// RD_DATA | rvalid high, rdata held until rready
module axi_lite_register_file
  import axi_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_COUNT = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ADDRESS_WIDTH-1:0]             awaddr,
  input  logic [2:0]                           awprot,
  input  logic                                 awvalid,
  output logic                                 awready,
  input  logic [DATA_WIDTH-1:0]                wdata,
  input  logic [DATA_WIDTH/8-1:0]              wstrb,
  input  logic                                 wvalid,
  output logic                                 wready,
  output logic [1:0]                           bresp,
  output logic                                 bvalid,
  input  logic                                 bready,
  input  logic [ADDRESS_WIDTH-1:0]             araddr,
  input  logic [2:0]                           arprot,
  input  logic                                 arvalid,
  output logic                                 arready,
  output logic [DATA_WIDTH-1:0]                rdata,
  output logic [1:0]                           rresp,
  output logic                                 rvalid,
  input  logic                                 rready,
  output logic [REGISTER_COUNT*DATA_WIDTH-1:0] registers,
  output logic [REGISTER_COUNT-1:0]            write_pulse
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(STRB_WIDTH);
  localparam int INDEX_WIDTH = ADDRESS_WIDTH - OFFSET_BITS;

  logic                            live_q, live_d;
  wr_state_e                       wr_state_q, wr_state_d;
  axi_resp_e                       bresp_q, bresp_d;
  logic [REGISTER_COUNT-1:0]       write_pulse_q, write_pulse_d;
  logic [DATA_WIDTH-1:0]           regs_q [REGISTER_COUNT];
  logic [DATA_WIDTH-1:0]           regs_d [REGISTER_COUNT];
  rd_state_e                       rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0]           rdata_q, rdata_d;
  axi_resp_e                       rresp_q, rresp_d;

  logic                            cap_fire;
  logic [ADDRESS_WIDTH-1:0]        cap_addr;
  logic [DATA_WIDTH-1:0]           cap_data;
  logic [STRB_WIDTH-1:0]           cap_strb;
  logic [INDEX_WIDTH-1:0]          wr_idx, rd_idx;
  axi_resp_e                       wr_resp, rd_resp;
  logic                            unused_bits;

  assign unused_bits = ^{awprot, arprot, cap_addr, araddr};

  assign wr_idx = cap_addr[ADDRESS_WIDTH-1:OFFSET_BITS];
  assign rd_idx = araddr[ADDRESS_WIDTH-1:OFFSET_BITS];

`ifdef AXI_LITE_REGISTER_FILE_DECODE_ERROR_EN
  localparam logic [INDEX_WIDTH:0] REG_LIMIT = (INDEX_WIDTH+1)'(REGISTER_COUNT);
  assign wr_resp = ({1'b0, wr_idx} < REG_LIMIT) ? OKAY : SLVERR;
  assign rd_resp = ({1'b0, rd_idx} < REG_LIMIT) ? OKAY : SLVERR;
`else
  assign wr_resp = OKAY;
  assign rd_resp = OKAY;
`endif

  axi_lite_write_capture #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_capture (
    .clk        (clk),
    .reset      (reset),
    .enable     (live_q),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .clear      (bvalid & bready),
    .both_ready (cap_fire),
    .addr       (cap_addr),
    .data       (cap_data),
    .strb       (cap_strb)
  );

  // Holds the ready outputs low through reset and for the reset-release edge itself.
  assign live_d = 1'b1;

  always_comb begin
    wr_state_d    = wr_state_q;
    bresp_d       = bresp_q;
    write_pulse_d = '0;
    regs_d        = regs_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (cap_fire) begin
          wr_state_d = WR_RESP;
          bresp_d    = wr_resp;
          for (int i = 0; i < REGISTER_COUNT; i++) begin
            if (wr_idx == INDEX_WIDTH'(i)) begin
              write_pulse_d[i] = 1'b1;
              for (int k = 0; k < STRB_WIDTH; k++) begin
                if (cap_strb[k]) regs_d[i][k*8 +: 8] = cap_data[k*8 +: 8];
              end
            end
          end
        end
      end
      WR_RESP: begin
        if (bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Reads sample regs_q, so a same-cycle write to the same index returns the old value.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (arvalid && arready) begin
          rd_state_d = RD_DATA;
          rresp_d    = rd_resp;
          rdata_d    = '0;
          for (int i = 0; i < REGISTER_COUNT; i++) begin
            if (rd_idx == INDEX_WIDTH'(i)) rdata_d = regs_q[i];
          end
        end
      end
      RD_DATA: begin
        if (rready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q        <= 1'b0;
      wr_state_q    <= WR_IDLE;
      bresp_q       <= OKAY;
      write_pulse_q <= '0;
      regs_q        <= '{default: '0};
      rd_state_q    <= RD_IDLE;
      rdata_q       <= '0;
      rresp_q       <= OKAY;
    end else begin
      live_q        <= live_d;
      wr_state_q    <= wr_state_d;
      bresp_q       <= bresp_d;
      write_pulse_q <= write_pulse_d;
      regs_q        <= regs_d;
      rd_state_q    <= rd_state_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
    end
  end

  assign bvalid      = (wr_state_q == WR_RESP);
  assign bresp       = bresp_q;
  assign rvalid      = (rd_state_q == RD_DATA);
  assign arready     = live_q & (rd_state_q == RD_IDLE);
  assign rdata       = rdata_q;
  assign rresp       = rresp_q;
  assign write_pulse = write_pulse_q;

  for (genvar g = 0; g < REGISTER_COUNT; g++) begin : g_export
    assign registers[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axi_lite_register_file.sv
// Directed self-checking bench for axi_lite_register_file (default parameters).
module tb_axi_lite_register_file;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [7:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [511:0] registers;
  logic [15:0]  write_pulse;

  int total = 0;
  int bad   = 0;
  logic [511:0] exp_regs;

`ifdef AXI_LITE_REGISTER_FILE_DECODE_ERROR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  always #5 clk = ~clk;

  axi_lite_register_file dut (
    .clk         (clk),
    .reset       (reset),
    .awaddr      (awaddr),
    .awprot      (awprot),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .araddr      (araddr),
    .arprot      (arprot),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .registers   (registers),
    .write_pulse (write_pulse)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    exp_regs = '0;
    step(); step(); step();
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_regs", registers, exp_regs);
    check("rst_pulse", write_pulse, 0);
    check("rst_rdata", rdata, 0);

    reset = 1'b0;
    step();
    check("rel_awready", awready, 1);
    check("rel_wready", wready, 1);
    check("rel_arready", arready, 1);

    // read of a cleared register
    arvalid = 1; araddr = 8'h04;
    step();
    arvalid = 0;
    check("rd04_rvalid", rvalid, 1);
    check("rd04_rdata", rdata, 32'h0);
    check("rd04_rresp", rresp, 2'b00);
    check("rd04_arready", arready, 0);
    rready = 1;
    step();
    check("rd04_done", rvalid, 0);
    check("rd04_arready_back", arready, 1);
    rready = 0;

    // AW and W in the same cycle
    awvalid = 1; awaddr = 8'h08; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    exp_regs[2*32 +: 32] = 32'hDEADBEEF;
    check("wr08_regs", registers, exp_regs);
    check("wr08_pulse", write_pulse, 16'h0004);
    check("wr08_bvalid", bvalid, 1);
    check("wr08_bresp", bresp, 2'b00);
    check("wr08_awready", awready, 0);
    bready = 1;
    step();
    check("wr08_pulse_off", write_pulse, 0);
    check("wr08_bdone", bvalid, 0);
    bready = 0;

    // W three cycles ahead of AW, byte 0 only
    wvalid = 1; wdata = 32'h000000AA; wstrb = 4'h1;
    step();
    wvalid = 0;
    check("wfirst_wready", wready, 0);
    check("wfirst_awready", awready, 1);
    check("wfirst_bvalid", bvalid, 0);
    step(); step();
    check("wfirst_regs_wait", registers, exp_regs);
    awvalid = 1; awaddr = 8'h08;
    step();
    awvalid = 0;
    exp_regs[2*32 +: 32] = 32'hDEADBEAA;
    check("wfirst_regs", registers, exp_regs);
    check("wfirst_bvalid_on", bvalid, 1);
    check("wfirst_pulse", write_pulse, 16'h0004);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bhold_bvalid", bvalid, 1);
      check("bhold_bresp", bresp, 2'b00);
      check("bhold_awready", awready, 0);
      check("bhold_pulse", write_pulse, 0);
    end
    bready = 1;
    step();
    check("bhold_done", bvalid, 0);
    bready = 0;

    // out-of-range write and read
    awvalid = 1; awaddr = 8'hFC; wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    check("oor_bvalid", bvalid, 1);
    check("oor_regs", registers, exp_regs);
    check("oor_pulse", write_pulse, 0);
    check("oor_bresp", bresp, ERR_RESP);
    bready = 1;
    arvalid = 1; araddr = 8'hFC;
    step();
    arvalid = 0;
    check("oor_bdone", bvalid, 0);
    check("oor_rdata", rdata, 0);
    check("oor_rresp", rresp, ERR_RESP);
    rready = 1;
    step();
    rready = 0;

    // register[2]=1 with bready already high: bvalid one cycle only
    awvalid = 1; awaddr = 8'h08; wvalid = 1; wdata = 32'h1; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    check("wr1_bvalid", bvalid, 1);
    step();
    check("wr1_bvalid_one", bvalid, 0);

    // AR racing a write to the same register
    awvalid = 1; awaddr = 8'h08; wvalid = 1; wdata = 32'h2; wstrb = 4'hF;
    arvalid = 1; araddr = 8'h08;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    exp_regs[2*32 +: 32] = 32'h2;
    check("race_regs", registers, exp_regs);
    check("race_rvalid", rvalid, 1);
    check("race_rdata_old", rdata, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rhold_rvalid", rvalid, 1);
      check("rhold_rdata", rdata, 32'h1);
      check("rhold_arready", arready, 0);
    end
    rready = 1;
    step();
    check("rhold_done", rvalid, 0);
    check("rhold_arready_back", arready, 1);
    arvalid = 1; araddr = 8'h0B;
    step();
    arvalid = 0;
    check("race_reread", rdata, 32'h2);
    step();
    rready = 0;

    // reset with an AW-only beat pending
    bready = 0;
    awvalid = 1; awaddr = 8'h00;
    step();
    awvalid = 0;
    check("pend_awready", awready, 0);
    reset = 1;
    step();
    exp_regs = '0;
    check("pend_rst_bvalid", bvalid, 0);
    check("pend_rst_regs", registers, exp_regs);
    reset = 0;
    step();
    check("pend_rel_awready", awready, 1);
    wvalid = 1; wdata = 32'h55; wstrb = 4'hF;
    step();
    wvalid = 0;
    check("pend_no_bvalid", bvalid, 0);
    check("pend_w_held", wready, 0);
    awvalid = 1; awaddr = 8'h00;
    step();
    awvalid = 0;
    exp_regs[0 +: 32] = 32'h55;
    check("post_bvalid", bvalid, 1);
    check("post_pulse", write_pulse, 16'h0001);
    check("post_regs", registers, exp_regs);
    bready = 1;
    step();
    check("post_bdone", bvalid, 0);

    // byte offset ignored, bytes 1 and 2 only
    awvalid = 1; awaddr = 8'h01; wvalid = 1; wdata = 32'hAABBCCDD; wstrb = 4'b0110;
    step();
    awvalid = 0; wvalid = 0;
    exp_regs[0 +: 32] = 32'h00BBCC55;
    check("strb_regs", registers, exp_regs);
    check("strb_pulse", write_pulse, 16'h0001);
    step();

    // wstrb=0 on the last register still pulses
    awvalid = 1; awaddr = 8'h3C; wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'h0;
    step();
    awvalid = 0; wvalid = 0;
    check("strb0_pulse", write_pulse, 16'h8000);
    check("strb0_regs", registers, exp_regs);
    check("strb0_bresp", bresp, 2'b00);
    step();
    check("strb0_done", bvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_register_file.md
Name: axi_lite_register_file

Overview:
- AXI-Lite slave: a bank of REGISTER_COUNT control/status registers, each DATA_WIDTH bits wide.
- Sits directly downstream of the team's AXI-Lite bus interface and terminates all five channels.
- Register contents are exported as a flat bus to peripheral logic, with a per-register write strobe pulse.
- Read and write paths are independent state machines.

Parameters:
- ADDRESS_WIDTH, 8, width of awaddr/araddr.
- DATA_WIDTH, 32, width of wdata/rdata and of each register; multiple of 8.
- REGISTER_COUNT, 16, number of registers; 1..2**(ADDRESS_WIDTH-log2(DATA_WIDTH/8)).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- awaddr  in  ADDRESS_WIDTH  write address.
- awprot  in  3  ignored.
- awvalid / awready  in / out  1  write-address handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables.
- wvalid / wready  in / out  1  write-data handshake.
- bresp  out  2  write response.
- bvalid / bready  out / in  1  write-response handshake.
- araddr  in  ADDRESS_WIDTH  read address.
- arprot  in  3  ignored.
- arvalid / arready  in / out  1  read-address handshake.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid / rready  out / in  1  read-data handshake.
- registers  out  REGISTER_COUNT*DATA_WIDTH  register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- write_pulse  out  REGISTER_COUNT  bit i is high for one cycle when register i is written.

Behaviour:
- Index = addr[ADDRESS_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits are ignored. Index >= REGISTER_COUNT is out of range.
- Reset:
  - all registers 0; write_pulse 0.
  - awready, wready, arready, bvalid, rvalid 0.
  - bresp, rresp 2'b00; rdata 0.
  - Any transaction in flight at reset is discarded.
  - awready, wready, arready rise in the first cycle after reset deasserts.
- Write FSM, states WR_IDLE and WR_RESP:
  - WR_IDLE:
    - awready=1 until the AW beat is captured; wready=1 until the W beat is captured.
    - AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
    - When both are held (at the later handshake edge), move to WR_RESP.
  - Entry edge into WR_RESP:
    - Registers update: byte k of register[index] takes wdata byte k iff wstrb[k]=1.
    - write_pulse[index]=1 for exactly this one cycle, asserted for in-range addresses even if wstrb=0.
    - bvalid=1.
    - Latency: update and bvalid are visible 1 cycle after the later of the AW/W handshakes.
  - WR_RESP:
    - awready=wready=0.
    - bvalid and bresp held until bready=1, then return to WR_IDLE.
    - If bready is already high, bvalid lasts exactly one cycle.
  - Out-of-range write: no register change, no pulse; response still issued.
- Read FSM, states RD_IDLE and RD_DATA:
  - RD_IDLE: arready=1. On handshake, rdata is registered from the current register value and rvalid=1 on the next cycle.
  - RD_DATA: arready=0; rdata and rresp held until rready=1, then return to RD_IDLE.
  - Out-of-range read returns rdata=0.
  - An AR handshake in the same cycle as a register update to the same index returns the old value.
- Read and write FSMs run concurrently with no cross-blocking.

Optional Feature:
- Macro: AXI_LITE_REGISTER_FILE_DECODE_ERROR_EN.
- Defined: out-of-range writes give bresp=SLVERR (2'b10) and out-of-range reads give rresp=SLVERR with rdata=0.
- Undefined: every response is OKAY (2'b00).
- In-range accesses are unaffected either way.

Decomposition:
- Shared package axi_lite_pkg holds:
  - response enum: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - write-state enum (WR_IDLE, WR_RESP) and read-state enum (RD_IDLE, RD_DATA).
- One natural sub-module, axi_lite_write_capture: latches the AW/W beats in either order and raises a "both captured" flag; cleared on the B handshake.
- Strobe merge and read mux stay in the top module.

Test Plan:
- Reset released → awready=wready=arready=1 next cycle; registers all 0; AR to 0x04 → rdata=0x00000000, rresp=OKAY.
- AW 0x08 and W 0xDEADBEEF with wstrb=4'hF in the same cycle → next cycle register[2]=0xDEADBEEF, write_pulse=0x0004 for one cycle, bvalid=1, bresp=OKAY.
- W 0x000000AA with wstrb=4'h1 three cycles before AW 0x08, register[2] previously 0xDEADBEEF → register[2]=0xDEADBEAA; bready held low 4 cycles → bvalid and bresp stable, awready=0 throughout.
- AW 0xFC (index 63, out of range) with W 0x12345678 → no register change, write_pulse=0; bresp=SLVERR with macro defined, OKAY without.
- AR 0x08 handshaked in the same cycle register[2] is updated 0x1→0x2 → rdata=0x1; rready low 3 cycles → rvalid and rdata held and arready=0 until rready.
- reset asserted one cycle after an AW-only capture → bvalid never asserts and a subsequent full write to 0x00 behaves normally.
